// File: rtl/pc_sequencer.sv
// Next-PC unit for the multicycle CPU. It covers sequential, branch, jump, call and return
// modes, a circular return-address stack, trap entry/exit and alignment checking.
module pc_sequencer #(
  parameter int             W            = 32,
  parameter int             RAS_DEPTH    = 4,
  parameter logic [W-1:0]   RESET_VECTOR = {W{1'b0}},
  parameter logic [W-1:0]   TRAP_VECTOR  = W'(32'h0000_0080)
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic                         pc_we,
  input  logic [2:0]                   pc_src,
  input  logic [W-1:0]                 imm,
  input  logic [25:0]                  jaddr,
  input  logic [W-1:0]                 rs_val,
  input  logic                         trap,
  output logic [W-1:0]                 pc,
  output logic [W-1:0]                 pc_plus4,
  output logic [W-1:0]                 epc,
  output logic                         in_trap,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_unf,
  output logic                         misalign,
  output logic                         illegal
);

  localparam int             PW   = $clog2(RAS_DEPTH);
  localparam int             CW   = PW + 1;
  localparam logic [CW-1:0]  FULL = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BR   = 3'd1,
    SRC_JR   = 3'd2,
    SRC_J    = 3'd3,
    SRC_CALL = 3'd4,
    SRC_RET  = 3'd5,
    SRC_ERET = 3'd6,
    SRC_RSVD = 3'd7
  } src_e;

  logic [W-1:0]  pc_q, pc_d;
  logic [W-1:0]  epc_q, epc_d;
  logic          in_trap_q, in_trap_d;
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, unf_q, unf_d, mis_q, mis_d, ill_q, ill_d;
  logic [W-1:0]  ras_q [RAS_DEPTH];

  logic [W-1:0]  pc_plus4_s;
  logic [W-1:0]  jtgt_s;
  logic [W-1:0]  target_s;
  logic          align_s;
  logic          push_s;

  assign pc_plus4_s = pc_q + W'(32'd4);
  assign jtgt_s     = {pc_plus4_s[W-1:28], jaddr, 2'b00};

  // Next-state selection: trap beats pc_we, which beats hold.
  always_comb begin
    pc_d      = pc_q;
    epc_d     = epc_q;
    in_trap_d = in_trap_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    mis_d     = 1'b0;
    ill_d     = 1'b0;
    target_s  = {W{1'b0}};
    align_s   = 1'b0;
    push_s    = 1'b0;
    if (trap) begin
      pc_d = TRAP_VECTOR;
      if (!in_trap_q) begin
        epc_d     = pc_q;
        in_trap_d = 1'b1;
      end else begin
        epc_d = epc_q;
      end
    end else if (pc_we) begin
      case (src_e'(pc_src))
        SRC_SEQ: pc_d = pc_plus4_s;
        SRC_BR:  pc_d = pc_plus4_s + (imm << 2);
        SRC_JR: begin
          target_s = rs_val;
          align_s  = 1'b1;
        end
        SRC_J:   pc_d = jtgt_s;
        SRC_CALL: begin
          pc_d   = jtgt_s;
          push_s = 1'b1;
          top_d  = top_q + PW'(1);
          // A full stack keeps its count; the write lands on the oldest slot.
          if (cnt_q == FULL) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        SRC_RET: begin
          align_s = 1'b1;
          if (cnt_q != {CW{1'b0}}) begin
            target_s = ras_q[top_q];
            top_d    = top_q - PW'(1);
            cnt_d    = cnt_q - CW'(1);
          end else begin
            target_s = rs_val;
            unf_d    = 1'b1;
          end
        end
        SRC_ERET: begin
          target_s  = epc_q;
          align_s   = 1'b1;
          in_trap_d = 1'b0;
          ill_d     = ~in_trap_q;
        end
        default: ill_d = 1'b1;
      endcase
      if (align_s) begin
        pc_d  = {target_s[W-1:2], 2'b00};
        mis_d = |target_s[1:0];
      end else begin
        mis_d = 1'b0;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // Architectural state and one-cycle status pulses.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pc_q      <= RESET_VECTOR;
      epc_q     <= {W{1'b0}};
      in_trap_q <= 1'b0;
      top_q     <= {PW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      mis_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      in_trap_q <= in_trap_d;
      top_q     <= top_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      mis_q     <= mis_d;
      ill_q     <= ill_d;
    end
  end

  // Return-address storage; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      ras_q[top_d] <= pc_plus4_s;
    end
  end

  assign pc        = pc_q;
  assign pc_plus4  = pc_plus4_s;
  assign epc       = epc_q;
  assign in_trap   = in_trap_q;
  assign ras_count = cnt_q;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;
  assign misalign  = mis_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        clk;
  logic        Reset;
  logic        pc_we;
  logic [2:0]  pc_src;
  logic [31:0] imm;
  logic [25:0] jaddr;
  logic [31:0] rs_val;
  logic        trap;
  logic [31:0] pc, pc_plus4, epc;
  logic        in_trap;
  logic [2:0]  ras_count;
  logic        ras_ovf, ras_unf, misalign, illegal;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.W(32), .RAS_DEPTH(4)) dut (
    .clk(clk), .Reset(Reset), .pc_we(pc_we), .pc_src(pc_src), .imm(imm),
    .jaddr(jaddr), .rs_val(rs_val), .trap(trap), .pc(pc), .pc_plus4(pc_plus4),
    .epc(epc), .in_trap(in_trap), .ras_count(ras_count), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf), .misalign(misalign), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic we, input logic [2:0] src);
    pc_we  = we;
    pc_src = src;
    @(posedge clk);
    #1;
  endtask

  task automatic jr(input logic [31:0] addr);
    rs_val = addr;
    cyc(1'b1, 3'd2);
  endtask

  logic [31:0] ret_exp [4] = '{32'h104, 32'hC4, 32'h84, 32'h44};

  initial begin
    Reset = 1'b0; pc_we = 1'b0; pc_src = 3'd0; imm = 32'd0;
    jaddr = 26'd0; rs_val = 32'd0; trap = 1'b0;
    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_in_trap", {31'd0, in_trap}, 32'd0);
    check("rst_cnt", {29'd0, ras_count}, 32'd0);
    check("rst_pulses", {28'd0, ras_ovf, ras_unf, misalign, illegal}, 32'd0);
    Reset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 3'd0);
      check("hold_pc", pc, 32'h0);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 3'd0);
      check("seq_pc", pc, 32'(i * 4));
    end
    check("pc_plus4", pc_plus4, 32'd16);

    jr(32'h100);
    check("jr_aligned_mis", {31'd0, misalign}, 32'd0);
    imm = 32'hFFFF_FFFE;
    cyc(1'b1, 3'd1);
    check("br_neg", pc, 32'hFC);
    jr(32'h100);
    imm = 32'h10;
    cyc(1'b1, 3'd1);
    check("br_pos", pc, 32'h144);

    jr(32'h1000_0000);
    jaddr = 26'h10;
    cyc(1'b1, 3'd3);
    check("j_pc", pc, 32'h1000_0040);
    rs_val = 32'h2003;
    cyc(1'b1, 3'd2);
    check("jr_mis_pc", pc, 32'h2000);
    check("jr_mis_pulse", {31'd0, misalign}, 32'd1);
    cyc(1'b0, 3'd0);
    check("mis_clear", {31'd0, misalign}, 32'd0);

    jr(32'h0);
    for (int k = 1; k <= 5; k++) begin
      jaddr = 26'(k * 16);
      cyc(1'b1, 3'd4);
      check("call_pc", pc, 32'(k * 64));
      check("call_ovf", {31'd0, ras_ovf}, (k == 5) ? 32'd1 : 32'd0);
      check("call_cnt", {29'd0, ras_count}, (k >= 4) ? 32'd4 : 32'(k));
    end
    rs_val = 32'h500;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 3'd5);
      check("ret_pc", pc, ret_exp[k]);
      check("ret_unf", {31'd0, ras_unf}, 32'd0);
    end
    check("ret_cnt0", {29'd0, ras_count}, 32'd0);
    cyc(1'b1, 3'd5);
    check("unf_pc", pc, 32'h500);
    check("unf_pulse", {31'd0, ras_unf}, 32'd1);
    check("unf_cnt", {29'd0, ras_count}, 32'd0);

    jaddr = 26'h10;
    cyc(1'b1, 3'd4);
    check("wt_call", pc, 32'h40);
    cyc(1'b1, 3'd5);
    check("wt_ret", pc, 32'h504);

    jr(32'h200);
    trap = 1'b1;
    cyc(1'b1, 3'd0);
    trap = 1'b0;
    check("trap_pc", pc, 32'h80);
    check("trap_epc", epc, 32'h200);
    check("trap_in", {31'd0, in_trap}, 32'd1);
    cyc(1'b1, 3'd0);
    check("handler_pc", pc, 32'h84);
    trap = 1'b1;
    cyc(1'b1, 3'd0);
    trap = 1'b0;
    check("nest_pc", pc, 32'h80);
    check("nest_epc", epc, 32'h200);
    check("nest_in", {31'd0, in_trap}, 32'd1);
    cyc(1'b1, 3'd6);
    check("eret_pc", pc, 32'h200);
    check("eret_in", {31'd0, in_trap}, 32'd0);
    check("eret_ill", {31'd0, illegal}, 32'd0);

    cyc(1'b1, 3'd7);
    check("rsvd_pc", pc, 32'h200);
    check("rsvd_ill", {31'd0, illegal}, 32'd1);
    cyc(1'b0, 3'd0);
    check("ill_clear", {31'd0, illegal}, 32'd0);
    cyc(1'b1, 3'd6);
    check("eret_noT_pc", pc, 32'h200);
    check("eret_noT_ill", {31'd0, illegal}, 32'd1);

    jr(32'h300);
    check("pre_rst_pc", pc, 32'h300);
    Reset = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_pulse", {28'd0, ras_ovf, ras_unf, misalign, illegal}, 32'd0);
    #10;
    Reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
